// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: loads an N-bit word over valid/ready and shifts
// it out one bit per shift_en tick, with registered frame and done markers.
module piso_shift_tx #(
  parameter int unsigned N         = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         shift_en,
  output logic         s_out,
  output logic         s_frame,
  output logic         done_tick
);

  localparam int unsigned CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(N - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e         r_state, w_state_next;
  logic [N-1:0]   r_sreg, w_sreg_next;
  logic [CW-1:0]  r_cnt, w_cnt_next;
  logic           r_done, w_done_next;

  logic           w_last;
  logic           w_xfer;
  logic [N-1:0]   w_shifted;

  assign w_last    = (r_state == StShift) && (r_cnt == LastCnt);
  // Ready only depends on state and shift_en, never on din_valid.
  assign din_ready = (r_state == StIdle) || (w_last && shift_en);
  assign w_xfer    = din_valid && din_ready;

  // Shift toward the output end with zero fill.
  assign w_shifted = MSB_FIRST ? {r_sreg[N-2:0], 1'b0} : {1'b0, r_sreg[N-1:1]};

  always_comb begin
    w_state_next = r_state;
    w_sreg_next  = r_sreg;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_xfer) begin
          w_sreg_next  = din;
          w_cnt_next   = '0;
          w_state_next = StShift;
        end
      end
      StShift: begin
        if (shift_en) begin
          if (w_last) begin
            w_done_next = 1'b1;
            if (w_xfer) begin
              w_sreg_next = din;
              w_cnt_next  = '0;
            end else begin
              // Clearing the register returns s_out to 0 between words.
              w_sreg_next  = '0;
              w_cnt_next   = '0;
              w_state_next = StIdle;
            end
          end else begin
            w_sreg_next = w_shifted;
            w_cnt_next  = r_cnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_next = StIdle;
        w_sreg_next  = '0;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sreg  <= w_sreg_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
    end
  end

  assign s_out     = MSB_FIRST ? r_sreg[N-1] : r_sreg[0];
  assign s_frame   = (r_state == StShift);
  assign done_tick = r_done;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: an LSB-first and an MSB-first instance share stimulus.
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] din;
  logic       din_valid;
  logic       shift_en;
  logic       din_ready, s_out, s_frame, done_tick;
  logic       din_ready_m, s_out_m, s_frame_m, done_tick_m;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  piso_shift_tx #(.N(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .shift_en(shift_en), .s_out(s_out), .s_frame(s_frame), .done_tick(done_tick)
  );

  piso_shift_tx #(.N(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid), .din_ready(din_ready_m),
    .shift_en(shift_en), .s_out(s_out_m), .s_frame(s_frame_m), .done_tick(done_tick_m)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; din = '0; din_valid = 1'b0; shift_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (s_out !== 1'b0) begin n_err++; $display("FAIL rst_sout got %b want 0", s_out); end
    n_cmp++; if (s_frame !== 1'b0) begin n_err++; $display("FAIL rst_frame got %b want 0", s_frame); end
    n_cmp++; if (done_tick !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", done_tick); end
    n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", din_ready); end
    step(); step();
    reset_n = 1'b1;
    step();
    // Load 8'hFF, send 3 bits, then abort mid-word.
    din = 8'hFF; din_valid = 1'b1; shift_en = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (s_out !== 1'b1) begin n_err++; $display("FAIL rstw_sout c=%0d got %b want 1", c, s_out); end
      n_cmp++; if (s_frame !== 1'b1) begin n_err++; $display("FAIL rstw_frame c=%0d got %b want 1", c, s_frame); end
      step();
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (s_out !== 1'b0) begin n_err++; $display("FAIL abort_sout got %b want 0", s_out); end
    n_cmp++; if (s_frame !== 1'b0) begin n_err++; $display("FAIL abort_frame got %b want 0", s_frame); end
    n_cmp++; if (done_tick !== 1'b0) begin n_err++; $display("FAIL abort_done got %b want 0", done_tick); end
    n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready got %b want 1", din_ready); end
    din_valid = 1'b1;
    step();
    n_cmp++; if (s_frame !== 1'b0) begin n_err++; $display("FAIL rst_noload got %b want 0", s_frame); end
    din_valid = 1'b0;
    reset_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      n_cmp++; if (s_out !== 1'b0) begin n_err++; $display("FAIL post_rst_sout c=%0d got %b want 0", c, s_out); end
      n_cmp++; if (s_frame !== 1'b0) begin n_err++; $display("FAIL post_rst_frame c=%0d got %b want 0", c, s_frame); end
    end
  endtask

  task automatic test_single();
    logic [7:0] exp;
    exp = 8'hA5;
    din = 8'hA5; din_valid = 1'b1; shift_en = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      n_cmp++; if (s_out !== exp[c]) begin n_err++; $display("FAIL single_sout c=%0d got %b want %b", c, s_out, exp[c]); end
      n_cmp++; if (s_frame !== 1'b1) begin n_err++; $display("FAIL single_frame c=%0d got %b want 1", c, s_frame); end
      n_cmp++; if (done_tick !== 1'b0) begin n_err++; $display("FAIL single_done c=%0d got %b want 0", c, done_tick); end
      step();
    end
    n_cmp++; if (done_tick !== 1'b1) begin n_err++; $display("FAIL single_done_end got %b want 1", done_tick); end
    n_cmp++; if (s_frame !== 1'b0) begin n_err++; $display("FAIL single_frame_end got %b want 0", s_frame); end
    n_cmp++; if (s_out !== 1'b0) begin n_err++; $display("FAIL single_sout_end got %b want 0", s_out); end
    step();
    n_cmp++; if (done_tick !== 1'b0) begin n_err++; $display("FAIL single_done_pulse got %b want 0", done_tick); end
    n_cmp++; if (s_out !== 1'b0) begin n_err++; $display("FAIL single_sout_idle got %b want 0", s_out); end
  endtask

  task automatic test_slow_rate();
    logic [7:0] exp;
    exp = 8'h3C;
    din = 8'h3C; din_valid = 1'b1; shift_en = 1'b0;
    step();
    din_valid = 1'b0;
    for (int c = 0; c < 32; c++) begin
      shift_en = ((c % 4) == 3);
      #1;
      n_cmp++; if (s_out !== exp[c/4]) begin n_err++; $display("FAIL slow_sout c=%0d got %b want %b", c, s_out, exp[c/4]); end
      n_cmp++; if (din_ready !== (c == 31)) begin n_err++; $display("FAIL slow_ready c=%0d got %b want %b", c, din_ready, (c == 31)); end
      n_cmp++; if (s_frame !== 1'b1) begin n_err++; $display("FAIL slow_frame c=%0d got %b want 1", c, s_frame); end
      step();
    end
    shift_en = 1'b0;
    n_cmp++; if (done_tick !== 1'b1) begin n_err++; $display("FAIL slow_done got %b want 1", done_tick); end
    n_cmp++; if (s_frame !== 1'b0) begin n_err++; $display("FAIL slow_frame_end got %b want 0", s_frame); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    exp = 16'hF00F;
    din = 8'h0F; din_valid = 1'b1; shift_en = 1'b1;
    step();
    din = 8'hF0;
    for (int c = 0; c < 16; c++) begin
      din_valid = (c <= 7);
      #1;
      n_cmp++; if (s_out !== exp[c]) begin n_err++; $display("FAIL b2b_sout c=%0d got %b want %b", c, s_out, exp[c]); end
      n_cmp++; if (s_frame !== 1'b1) begin n_err++; $display("FAIL b2b_frame c=%0d got %b want 1", c, s_frame); end
      n_cmp++; if (done_tick !== (c == 8)) begin n_err++; $display("FAIL b2b_done c=%0d got %b want %b", c, done_tick, (c == 8)); end
      n_cmp++; if (din_ready !== (c == 7 || c == 15)) begin n_err++; $display("FAIL b2b_ready c=%0d got %b want %b", c, din_ready, (c == 7 || c == 15)); end
      step();
    end
    n_cmp++; if (done_tick !== 1'b1) begin n_err++; $display("FAIL b2b_done_end got %b want 1", done_tick); end
    n_cmp++; if (s_frame !== 1'b0) begin n_err++; $display("FAIL b2b_frame_end got %b want 0", s_frame); end
    step();
  endtask

  task automatic test_msb_first();
    logic [7:0] exp_m;
    logic [7:0] exp_l;
    exp_m = 8'h83;
    exp_l = 8'hC1;
    din = 8'hC1; din_valid = 1'b1; shift_en = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      n_cmp++; if (s_out_m !== exp_m[c]) begin n_err++; $display("FAIL msb_sout c=%0d got %b want %b", c, s_out_m, exp_m[c]); end
      n_cmp++; if (s_frame_m !== 1'b1) begin n_err++; $display("FAIL msb_frame c=%0d got %b want 1", c, s_frame_m); end
      n_cmp++; if (s_out !== exp_l[c]) begin n_err++; $display("FAIL lsb_sout c=%0d got %b want %b", c, s_out, exp_l[c]); end
      step();
    end
    n_cmp++; if (done_tick_m !== 1'b1) begin n_err++; $display("FAIL msb_done got %b want 1", done_tick_m); end
    n_cmp++; if (s_out_m !== 1'b0) begin n_err++; $display("FAIL msb_sout_end got %b want 0", s_out_m); end
    step();
  endtask

  task automatic test_mid_word_valid();
    logic [7:0] exp;
    logic       want;
    exp = 8'hAA;
    din = 8'h00; din_valid = 1'b1; shift_en = 1'b1;
    step();
    din_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c == 2) begin din_valid = 1'b1; din = 8'h55; end
      if (c == 6) din = 8'hAA;
      if (c == 8) din_valid = 1'b0;
      #1;
      want = (c < 8) ? 1'b0 : exp[c-8];
      n_cmp++; if (s_out !== want) begin n_err++; $display("FAIL mid_sout c=%0d got %b want %b", c, s_out, want); end
      n_cmp++; if (din_ready !== ((c % 8) == 7)) begin n_err++; $display("FAIL mid_ready c=%0d got %b want %b", c, din_ready, ((c % 8) == 7)); end
      n_cmp++; if (done_tick !== (c == 8)) begin n_err++; $display("FAIL mid_done c=%0d got %b want %b", c, done_tick, (c == 8)); end
      n_cmp++; if (s_frame !== 1'b1) begin n_err++; $display("FAIL mid_frame c=%0d got %b want 1", c, s_frame); end
      step();
    end
    n_cmp++; if (done_tick !== 1'b1) begin n_err++; $display("FAIL mid_done_end got %b want 1", done_tick); end
    n_cmp++; if (s_frame !== 1'b0) begin n_err++; $display("FAIL mid_frame_end got %b want 0", s_frame); end
    n_cmp++; if (s_out !== 1'b0) begin n_err++; $display("FAIL mid_sout_end got %b want 0", s_out); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_slow_rate();
    test_back_to_back();
    test_msb_first();
    test_mid_word_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
